// File: rtl/arith_seq_pkg.sv
// Shared types and helpers for the sequential arithmetic blocks
// (multiplier now, divider later).
package arith_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(n)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca.sv
// N-bit ripple-carry adder chained from full_adder cells.
module rca #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);

   logic [N:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < N; i++) begin : g_bit
      full_adder u_fa (
         .a   (a[i]),
         .b   (b[i]),
         .cin (c[i]),
         .sum (sum[i]),
         .cout(c[i+1])
      );
   end

   assign cout = c[N];

endmodule

// File: rtl/seq_arrmul.sv
// Sequential unsigned shift-and-add multiplier: one multiplier bit per clock
// through a single N-bit adder row, start/busy/done handshake.
module seq_arrmul
   import arith_seq_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] seq_arrmul_out
);

   localparam int unsigned CW = clog2(N);

   state_t           state_q;
   logic [N-1:0]     a_q;
   logic [2*N-1:0]   acc_q, acc_d;
   logic [CW-1:0]    cnt_q;
   logic             busy_q, done_q;
   logic [2*N-1:0]   out_q;

   logic [N-1:0]     addend, sum;
   logic             cout;

   // The multiplier occupies the low half of the accumulator: each right shift
   // retires one multiplier bit exactly as a product bit moves in from above.
   assign addend = acc_q[0] ? a_q : '0;

   rca #(.N(N)) u_rca (
      .a   (acc_q[2*N-1:N]),
      .b   (addend),
      .cin (1'b0),
      .sum (sum),
      .cout(cout)
   );

   assign acc_d = {cout, sum, acc_q[N-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         out_q   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  a_q     <= a;
                  acc_q   <= {{N{1'b0}}, b};
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            RUN: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(N - 1)) begin
                  out_q   <= acc_d;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign seq_arrmul_out = out_q;

endmodule

// File: tb/tb_seq_arrmul.sv
// Self-checking bench for seq_arrmul: directed table at N=4, corner sequences,
// randomized N=8 run against a plain-arithmetic product model.
module tb_seq_arrmul;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start4, start8;
   logic [3:0]  a4, b4;
   logic [7:0]  a8, b8;
   logic        busy4, done4, busy8, done8;
   logic [7:0]  out4;
   logic [15:0] out8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_arrmul #(.N(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .seq_arrmul_out(out4)
   );

   seq_arrmul #(.N(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .seq_arrmul_out(out8)
   );

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] prod;
   } vec_t;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         check("busy_done_exclusive4", 64'(busy4 & done4), 64'd0);
         check("busy_done_exclusive8", 64'(busy8 & done8), 64'd0);
      end
   end

   // Launch one product on the selected instance and wait for done (bounded).
   task automatic mul(input int unsigned w, input logic [7:0] av, input logic [7:0] bv,
                      input logic [15:0] expv, input string tag);
      int unsigned cyc;
      logic d;
      if (w == 4) begin start4 = 1'b1; a4 = av[3:0]; b4 = bv[3:0]; end
      else        begin start8 = 1'b1; a8 = av;      b8 = bv;      end
      @(posedge clk); #1;
      start4 = 1'b0;
      start8 = 1'b0;
      check({tag, "_busy_after_accept"}, 64'(w == 4 ? busy4 : busy8), 64'd1);
      cyc = 0;
      d = (w == 4) ? done4 : done8;
      while (!d && cyc < 4 * w) begin
         @(posedge clk); #1;
         cyc++;
         d = (w == 4) ? done4 : done8;
      end
      check({tag, "_latency"}, 64'(cyc), 64'(w));
      check({tag, "_product"}, 64'(w == 4 ? {8'd0, out4} : out8), 64'(expv));
      check({tag, "_busy_at_done"}, 64'(w == 4 ? busy4 : busy8), 64'd0);
   endtask

   initial begin
      vec_t vecs[8];
      int unsigned cyc, nd, t1, t2, ndone;
      logic [7:0]  p1, p2;
      logic [7:0]  ra, rb;
      logic [15:0] rexp;

      vecs[0] = '{4'd15, 4'd15, 8'd225};
      vecs[1] = '{4'd0,  4'd13, 8'd0};
      vecs[2] = '{4'd9,  4'd0,  8'd0};
      vecs[3] = '{4'd1,  4'd1,  8'd1};
      vecs[4] = '{4'd6,  4'd7,  8'd42};
      vecs[5] = '{4'd2,  4'd3,  8'd6};
      vecs[6] = '{4'd12, 4'd10, 8'd120};
      vecs[7] = '{4'd7,  4'd9,  8'd63};

      start4 = 1'b0; start8 = 1'b0;
      a4 = '0; b4 = '0; a8 = '0; b8 = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 64'(busy4), 64'd0);
      check("reset_done", 64'(done4), 64'd0);
      check("reset_out",  64'(out4),  64'd0);
      check("reset_out8", 64'(out8),  64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         mul(4, {4'd0, vecs[i].a}, {4'd0, vecs[i].b}, {8'd0, vecs[i].prod}, $sformatf("vec%0d", i));
         @(posedge clk); #1;
         check($sformatf("vec%0d_done_one_cycle", i), 64'(done4), 64'd0);
         check($sformatf("vec%0d_out_holds", i), 64'(out4), 64'(vecs[i].prod));
      end

      // start re-pulsed mid-run with different operands is ignored
      start4 = 1'b1; a4 = 4'd6; b4 = 4'd7;
      @(posedge clk); #1;
      start4 = 1'b0;
      @(posedge clk); #1;
      start4 = 1'b1; a4 = 4'd3; b4 = 4'd3;
      @(posedge clk); #1;
      start4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
      cyc = 2;
      while (!done4 && cyc < 16) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("midrun_latency", 64'(cyc), 64'd4);
      check("midrun_product", 64'(out4), 64'd42);
      ndone = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (done4) ndone++;
      end
      check("midrun_single_done", 64'(ndone), 64'd0);
      check("midrun_idle_busy", 64'(busy4), 64'd0);

      // reset asserted after iteration 2 aborts the operation
      start4 = 1'b1; a4 = 4'd5; b4 = 4'd11;
      @(posedge clk); #1;
      start4 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("abort_busy", 64'(busy4), 64'd0);
      check("abort_done", 64'(done4), 64'd0);
      check("abort_out",  64'(out4),  64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (done4 || busy4) ndone++;
      end
      check("abort_no_activity", 64'(ndone), 64'd0);
      mul(4, 8'd2, 8'd3, 16'd6, "after_abort");

      @(posedge clk); #1;
      // start held high: back-to-back products, done spaced N+1 cycles
      start4 = 1'b1; a4 = 4'd12; b4 = 4'd10;
      cyc = 0; nd = 0; t1 = 0; t2 = 0; p1 = '0; p2 = '0;
      while (nd < 2 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (done4) begin
            nd++;
            if (nd == 1) begin
               t1 = cyc; p1 = out4; a4 = 4'd7; b4 = 4'd9;
            end else begin
               t2 = cyc; p2 = out4; start4 = 1'b0;
            end
         end
      end
      check("b2b_done_count", 64'(nd), 64'd2);
      check("b2b_first_time", 64'(t1), 64'd5);
      check("b2b_first_prod", 64'(p1), 64'd120);
      check("b2b_second_prod", 64'(p2), 64'd63);
      check("b2b_spacing", 64'(t2 - t1), 64'd5);
      @(posedge clk); #1;
      check("b2b_back_to_idle", 64'(busy4), 64'd0);

      // N=8 randomized against the arithmetic model; consecutive calls start from DONE
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         rexp = {8'd0, ra} * {8'd0, rb};
         mul(8, ra, rb, rexp, $sformatf("rnd%0d", i));
      end
      mul(8, 8'd255, 8'd255, 16'd65025, "max8");

      @(posedge clk); #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
